window_addr_gen: RTL and testbench
==================================

WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 SHALL have parameter X_ROM_LEN, default 64: X window ROM depth.
REQ-002 SHALL have parameter Y_ROM_LEN, default 64: Y window ROM depth.
REQ-003 SHALL have parameter NUM_RESLUTION_PAIR, default 4: number of supported source/target pairs.
REQ-004 SHALL have parameter MAX_X_DECIMATION_FACTOR_LOG2, default 4: X window-length width.
REQ-005 SHALL have parameter MAX_Y_DECIMATION_FACTOR_LOG2, default 4: Y window-length width.
REQ-006 SHALL have parameter TAR_WIDTH, default 640: output pixels per line.
REQ-007 SHALL have parameter IN_ROM_DIR, default ".": directory of Xwindow_rom.mem, X_start_table.mem, Ywindow_rom.mem and Y_start_table.mem.
REQ-008 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-009 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-010 SHALL have port res_idx  in  clog2(NUM_RESLUTION_PAIR): resolution-pair select, sampled only at reset release or frame_start.
REQ-011 SHALL have port frame_start  in  1: synchronous one-cycle frame restart.
REQ-012 SHALL have port data_enable  in  1: one source pixel accepted this cycle.
REQ-013 SHALL have port en_output  in  1: one final output pixel emitted this cycle.
REQ-014 SHALL have port xw  out  clog2(X_ROM_LEN): current X window ROM address.
REQ-015 SHALL have port yw  out  clog2(Y_ROM_LEN): current Y window ROM address.
REQ-016 SHALL have port x_win_len  out  MAX_X_DECIMATION_FACTOR_LOG2: Xwindow_rom[xw], combinational.
REQ-017 SHALL have port y_win_len  out  MAX_Y_DECIMATION_FACTOR_LOG2: Ywindow_rom[yw], combinational.
REQ-018 SHALL have port x_first  out  1: the accepted pixel is the first of its X window (load count is 0).
REQ-019 SHALL have port x_last  out  1: the accepted pixel closes its X window; drives Xout_rdy.
REQ-020 SHALL have port y_adv  out  1: one-cycle pulse in the cycle yw advances or wraps.

Function
REQ-021 SHALL latch xs = X_start[res_idx] and xe = X_start[res_idx+1]-1, and likewise ys and ye from the Y start table; start tables hold NUM_RESLUTION_PAIR+1 entries.
REQ-022 SHALL hold a load counter cx; on data_enable, when cx == len-1, cx <= 0 and xw advances; otherwise cx <= cx+1.
REQ-023 SHALL treat a window length of 0 as 1.
REQ-024 SHALL advance xw to xw+1 when the X move count < xe-xs, else wrap xw to xs and clear the move count.
REQ-025 SHALL drive x_first = data_enable & (cx == 0) and x_last = data_enable & (cx == len-1), both combinational in the same cycle.
REQ-026 SHALL hold output counter po: if po == TAR_WIDTH then po <= 0, regardless of en_output; else if en_output then po <= po+1.
REQ-027 SHALL, in the cycle po == TAR_WIDTH, advance yw (wrapping to ys after ye-ys moves) and assert y_adv.
REQ-028 SHALL, on frame_start, re-latch the start table and load xw <= xs, yw <= ys, clearing all counters; frame_start overrides a same-cycle data_enable or en_output.
REQ-029 SHALL let the X chain (data_enable) and Y chain (en_output) act independently when both are asserted in one cycle.
REQ-030 SHALL hold xw, yw and all counters when data_enable and en_output are low.

Reset
REQ-031 SHALL on rst load xw = xs(res_idx), yw = ys(res_idx), cx = 0, po = 0, all move counts = 0 and y_adv = 0.
REQ-032 SHALL, if rst asserts mid-window, abort the partial window with no x_last and no y_adv.

Structure
REQ-033 SHALL place the ROM length, LOG2 width and decimation-factor constants in shared package downscaler_pkg.
REQ-034 SHALL instantiate sub-module window_rom twice (X and Y): $readmemh-initialised, asynchronous-read, with one window array and one start table each.

Verification
REQ-035 SHALL cover: X_start = {0,3,5}, Xwindow = {2,3,2}, res_idx = 0, data_enable continuous -> xw = 0,0,1,1,1,2,2,0; x_last on pixels 2, 5 and 7.
REQ-036 SHALL cover: TAR_WIDTH = 4, en_output continuous -> po = 1..4 with y_adv at po = 4 and no increment that cycle; yw wraps to ys after ye-ys+1 advances.
REQ-037 SHALL cover: Xwindow entry 0 -> every accepted pixel gives x_first = x_last = 1 and xw advances each pixel.
REQ-038 SHALL cover: rst asserted with cx = 1 of a length-3 window -> next pixel after release shows x_first = 1 and xw = xs.
REQ-039 SHALL cover: res_idx changed 0->1 mid-frame with no frame_start -> no effect; after frame_start, xw = 3 and yw = Y_start[1].
REQ-040 SHALL cover: frame_start coincident with data_enable and en_output -> counters cleared; the pixel and the output are not counted.

Source files
------------

// File: rtl/downscaler_pkg.sv
// Shared constants for the downscaler window address path.
// Holds default ROM geometry and decimation widths.
package downscaler_pkg;

  localparam int ROM_LEN       = 64;
  localparam int DEC_LOG2      = 4;
  localparam int NUM_PAIRS     = 4;
  localparam int TAR_WIDTH_DEF = 640;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/window_rom.sv
// Asynchronous-read window-length ROM plus start table.
// Contents come from packed parameters; entry i sits at [i*W +: W].
module window_rom #(
  parameter int LEN   = 64,
  parameter int DW    = 4,
  parameter int NPAIR = 4,
  parameter int AW    = $clog2(LEN),
  parameter int SW    = AW + 1,
  parameter int IW    = $clog2(NPAIR),
  parameter logic [LEN*DW-1:0]       WIN_INIT   = '0,
  parameter logic [(NPAIR+1)*SW-1:0] START_INIT = '0
) (
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] sel,
  output logic [DW-1:0] win_len,
  output logic [SW-1:0] start_lo,
  output logic [SW-1:0] start_hi
);

  logic [DW-1:0] win_mem   [LEN];
  logic [SW-1:0] start_mem [NPAIR+1];
  logic [IW:0]   sel_lo;
  logic [IW:0]   sel_hi;

  for (genvar i = 0; i < LEN; i++) begin : g_win
    assign win_mem[i] = WIN_INIT[i*DW +: DW];
  end

  for (genvar i = 0; i <= NPAIR; i++) begin : g_start
    assign start_mem[i] = START_INIT[i*SW +: SW];
  end

  assign sel_lo   = {1'b0, sel};
  assign sel_hi   = sel_lo + (IW+1)'(1);
  assign win_len  = win_mem[addr];
  assign start_lo = start_mem[sel_lo];
  assign start_hi = start_mem[sel_hi];

endmodule

// File: rtl/window_addr_gen.sv
// Walks X/Y window ROM addresses for the downscaler.
// X steps on accepted pixels, Y steps once per full output line.
module window_addr_gen
  import downscaler_pkg::*;
#(
  parameter int X_ROM_LEN                    = ROM_LEN,
  parameter int Y_ROM_LEN                    = ROM_LEN,
  parameter int NUM_RESLUTION_PAIR           = NUM_PAIRS,
  parameter int MAX_X_DECIMATION_FACTOR_LOG2 = DEC_LOG2,
  parameter int MAX_Y_DECIMATION_FACTOR_LOG2 = DEC_LOG2,
  parameter int TAR_WIDTH                    = TAR_WIDTH_DEF,
  parameter     IN_ROM_DIR                   = ".",
  parameter logic [X_ROM_LEN*MAX_X_DECIMATION_FACTOR_LOG2-1:0]
    X_WIN_INIT = '0,
  parameter logic [(NUM_RESLUTION_PAIR+1)*($clog2(X_ROM_LEN)+1)-1:0]
    X_START_INIT = '0,
  parameter logic [Y_ROM_LEN*MAX_Y_DECIMATION_FACTOR_LOG2-1:0]
    Y_WIN_INIT = '0,
  parameter logic [(NUM_RESLUTION_PAIR+1)*($clog2(Y_ROM_LEN)+1)-1:0]
    Y_START_INIT = '0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [$clog2(NUM_RESLUTION_PAIR)-1:0]   res_idx,
  input  logic                                    frame_start,
  input  logic                                    data_enable,
  input  logic                                    en_output,
  output logic [$clog2(X_ROM_LEN)-1:0]            xw,
  output logic [$clog2(Y_ROM_LEN)-1:0]            yw,
  output logic [MAX_X_DECIMATION_FACTOR_LOG2-1:0] x_win_len,
  output logic [MAX_Y_DECIMATION_FACTOR_LOG2-1:0] y_win_len,
  output logic                                    x_first,
  output logic                                    x_last,
  output logic                                    y_adv
);

  localparam int XAW = $clog2(X_ROM_LEN);
  localparam int YAW = $clog2(Y_ROM_LEN);
  localparam int XSW = XAW + 1;
  localparam int YSW = YAW + 1;
  localparam int IW  = $clog2(NUM_RESLUTION_PAIR);
  localparam int XL  = MAX_X_DECIMATION_FACTOR_LOG2;
  localparam int PW  = addr_w(TAR_WIDTH + 1);

  logic [XSW-1:0] xs_lo, xs_hi, x_span_new;
  logic [YSW-1:0] ys_lo, ys_hi, y_span_new;
  logic [XAW-1:0] xs_q;
  logic [YAW-1:0] ys_q;
  logic [XSW-1:0] xspan_q, mvx;
  logic [YSW-1:0] yspan_q, mvy;
  logic [XL-1:0]  cx, x_len_m1;
  logic [PW-1:0]  po;
  logic           x_end, po_full, gate;

  window_rom #(
    .LEN(X_ROM_LEN), .DW(XL), .NPAIR(NUM_RESLUTION_PAIR),
    .AW(XAW), .SW(XSW), .IW(IW),
    .WIN_INIT(X_WIN_INIT), .START_INIT(X_START_INIT)
  ) u_xrom (
    .addr(xw), .sel(res_idx), .win_len(x_win_len),
    .start_lo(xs_lo), .start_hi(xs_hi)
  );

  window_rom #(
    .LEN(Y_ROM_LEN), .DW(MAX_Y_DECIMATION_FACTOR_LOG2),
    .NPAIR(NUM_RESLUTION_PAIR),
    .AW(YAW), .SW(YSW), .IW(IW),
    .WIN_INIT(Y_WIN_INIT), .START_INIT(Y_START_INIT)
  ) u_yrom (
    .addr(yw), .sel(res_idx), .win_len(y_win_len),
    .start_lo(ys_lo), .start_hi(ys_hi)
  );

  // Span is the number of moves before wrapping: end - start.
  assign x_span_new = xs_hi - xs_lo - XSW'(1);
  assign y_span_new = ys_hi - ys_lo - YSW'(1);

  // A zero-length window behaves as length one.
  assign x_len_m1 = (x_win_len == '0) ? '0 : x_win_len - XL'(1);
  assign x_end    = (cx == x_len_m1);
  assign po_full  = (po == PW'(TAR_WIDTH));
  assign gate     = ~rst & ~frame_start;

  assign x_first = gate & data_enable & (cx == '0);
  assign x_last  = gate & data_enable & x_end;
  assign y_adv   = gate & po_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q    <= xs_lo[XAW-1:0];
      xspan_q <= x_span_new;
      xw      <= xs_lo[XAW-1:0];
      cx      <= '0;
      mvx     <= '0;
    end else if (frame_start) begin
      xs_q    <= xs_lo[XAW-1:0];
      xspan_q <= x_span_new;
      xw      <= xs_lo[XAW-1:0];
      cx      <= '0;
      mvx     <= '0;
    end else if (data_enable) begin
      if (x_end) begin
        cx <= '0;
        if (mvx < xspan_q) begin
          xw  <= xw + XAW'(1);
          mvx <= mvx + XSW'(1);
        end else begin
          xw  <= xs_q;
          mvx <= '0;
        end
      end else begin
        cx <= cx + XL'(1);
      end
    end
  end

  // The line end is consumed in its own cycle whether or not a pixel is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ys_q    <= ys_lo[YAW-1:0];
      yspan_q <= y_span_new;
      yw      <= ys_lo[YAW-1:0];
      po      <= '0;
      mvy     <= '0;
    end else if (frame_start) begin
      ys_q    <= ys_lo[YAW-1:0];
      yspan_q <= y_span_new;
      yw      <= ys_lo[YAW-1:0];
      po      <= '0;
      mvy     <= '0;
    end else if (po_full) begin
      po <= '0;
      if (mvy < yspan_q) begin
        yw  <= yw + YAW'(1);
        mvy <= mvy + YSW'(1);
      end else begin
        yw  <= ys_q;
        mvy <= '0;
      end
    end else if (en_output) begin
      po <= po + PW'(1);
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// Vector-table bench for window_addr_gen with a small ROM image.
// Expected outputs are queued per driven cycle and checked at negedge.
module tb_window_addr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] res_idx = 1'b0;
  logic       frame_start = 1'b0;
  logic       data_enable = 1'b0;
  logic       en_output = 1'b0;
  logic [2:0] xw, yw;
  logic [3:0] x_win_len, y_win_len;
  logic       x_first, x_last, y_adv;

  typedef struct {
    string name;
    bit    r, fs, de, eo, ri;
    int    xw, yw;
    bit    xf, xl, ya;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xrom[8] = '{2, 3, 2, 0, 0, 1, 1, 1};
  int   yrom[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  window_addr_gen #(
    .X_ROM_LEN(8), .Y_ROM_LEN(8), .NUM_RESLUTION_PAIR(2),
    .MAX_X_DECIMATION_FACTOR_LOG2(4),
    .MAX_Y_DECIMATION_FACTOR_LOG2(4),
    .TAR_WIDTH(4), .IN_ROM_DIR("."),
    .X_WIN_INIT(32'h1110_0232), .X_START_INIT(12'h530),
    .Y_WIN_INIT(32'h8765_4321), .Y_START_INIT(12'h520)
  ) dut (
    .clk(clk), .rst(rst), .res_idx(res_idx),
    .frame_start(frame_start), .data_enable(data_enable),
    .en_output(en_output), .xw(xw), .yw(yw),
    .x_win_len(x_win_len), .y_win_len(y_win_len),
    .x_first(x_first), .x_last(x_last), .y_adv(y_adv)
  );

  always #5 clk = ~clk;

  function automatic void add(string n, bit r, bit fs, bit de,
                              bit eo, bit ri, int exw, int eyw,
                              bit xf, bit xl, bit ya);
    vec_t v;
    v.name = n; v.r = r; v.fs = fs; v.de = de; v.eo = eo;
    v.ri = ri; v.xw = exw; v.yw = eyw;
    v.xf = xf; v.xl = xl; v.ya = ya;
    tbl.push_back(v);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [3:0] exl, eyl;
      e = sb.pop_front();
      exl = 4'(xrom[e.xw]);
      eyl = 4'(yrom[e.yw]);
      checks++;
      if (xw !== 3'(e.xw) || yw !== 3'(e.yw) ||
          x_first !== e.xf || x_last !== e.xl ||
          y_adv !== e.ya || x_win_len !== exl ||
          y_win_len !== eyl) begin
        errors++;
        $display("FAIL %s: got xw=%0d yw=%0d xf=%0b xl=%0b ya=%0b xlen=%0d ylen=%0d want xw=%0d yw=%0d xf=%0b xl=%0b ya=%0b xlen=%0d ylen=%0d",
                 e.name, xw, yw, x_first, x_last, y_adv,
                 x_win_len, y_win_len, e.xw, e.yw, e.xf, e.xl,
                 e.ya, exl, eyl);
      end
    end
  end

  initial begin
    add("reset", 1,0,0,0,0, 0,0, 0,0,0);
    add("xrun1", 0,0,1,0,0, 0,0, 1,0,0);
    add("xrun2", 0,0,1,0,0, 0,0, 0,1,0);
    add("xrun3", 0,0,1,0,0, 1,0, 1,0,0);
    add("xrun4", 0,0,1,0,0, 1,0, 0,0,0);
    add("xrun5", 0,0,1,0,0, 1,0, 0,1,0);
    add("xrun6", 0,0,1,0,0, 2,0, 1,0,0);
    add("xrun7", 0,0,1,0,0, 2,0, 0,1,0);
    add("xwrap", 0,0,1,0,0, 0,0, 1,0,0);
    add("fs_clr", 0,1,0,0,0, 0,0, 0,0,0);
    for (int k = 0; k < 11; k++)
      add("yline", 0,0,0,1,0, 0,(k/5)%2, 0,0,(k%5)==4);
    add("idle1", 0,0,0,0,0, 0,0, 0,0,0);
    add("idle2", 0,0,0,0,0, 0,0, 0,0,0);
    add("fs_clr2", 0,1,0,0,0, 0,0, 0,0,0);
    add("both1", 0,0,1,1,0, 0,0, 1,0,0);
    add("both2", 0,0,1,1,0, 0,0, 0,1,0);
    add("both3", 0,0,1,1,0, 1,0, 1,0,0);
    add("both4", 0,0,1,1,0, 1,0, 0,0,0);
    add("both5", 0,0,1,1,0, 1,0, 0,1,1);
    add("both6", 0,0,1,1,0, 2,1, 1,0,0);
    add("fs_ovr", 0,1,1,1,0, 2,1, 0,0,0);
    add("post1", 0,0,1,0,0, 0,0, 1,0,0);
    add("post2", 0,0,1,1,0, 0,0, 0,1,0);
    add("post3", 0,0,0,1,0, 1,0, 0,0,0);
    add("post4", 0,0,0,1,0, 1,0, 0,0,0);
    add("post5", 0,0,0,1,0, 1,0, 0,0,0);
    add("post6", 0,0,0,0,0, 1,0, 0,0,1);
    add("mid1", 0,0,1,0,0, 1,1, 1,0,0);
    add("rst_mid", 1,0,1,0,0, 0,0, 0,0,0);
    add("rel1", 0,0,1,0,0, 0,0, 1,0,0);
    add("rel2", 0,0,1,0,0, 0,0, 0,1,0);
    add("ri_noeff", 0,0,1,0,1, 1,0, 1,0,0);
    add("fs_ri1", 0,1,0,0,1, 1,0, 0,0,0);
    add("zlen1", 0,0,1,0,1, 3,2, 1,1,0);
    add("zlen2", 0,0,1,0,1, 4,2, 1,1,0);
    add("zlen3", 0,0,1,0,1, 3,2, 1,1,0);
    add("zlen4", 0,0,1,0,1, 4,2, 1,1,0);
    for (int k = 0; k < 16; k++)
      add("yline1", 0,0,0,1,1, 3,2+(k/5)%3, 0,0,(k%5)==4);

    repeat (3) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst         = tbl[i].r;
      frame_start = tbl[i].fs;
      data_enable = tbl[i].de;
      en_output   = tbl[i].eo;
      res_idx     = tbl[i].ri;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; frame_start = 1'b0;
    data_enable = 1'b0; en_output = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
